// File: rtl/rapid_pkg.sv
// RAPID core shared types.
// Memory sizes, stage control bundle and memory-stage states.
package rapid_pkg;

  typedef enum logic [2:0] {
    MEM_B  = 3'b000,
    MEM_H  = 3'b001,
    MEM_W  = 3'b010,
    MEM_BU = 3'b100,
    MEM_HU = 3'b101
  } mem_size_e;

  typedef struct packed {
    logic      reg_write;
    logic      mem_read;
    logic      mem_write;
    mem_size_e mem_size;
  } control_s;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } mem_state_e;

  function automatic logic is_aligned(
    input mem_size_e  size,
    input logic [1:0] off
  );
    logic ok;
    case (size)
      MEM_H, MEM_HU: ok = ~off[0];
      MEM_W:         ok = (off == 2'b00);
      default:       ok = 1'b1;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for stores and
// lane extraction plus extension for loads.
module mem_lane_align
  import rapid_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  mem_size_e        size,
  input  logic [1:0]       off,
  input  logic             load,
  input  logic [XLEN-1:0]  data,
  output logic [3:0]       be,
  output logic [XLEN-1:0]  result
);

  logic [XLEN-1:0] shifted;

  always_comb begin
    shifted = data >> {off, 3'b000};
    be      = 4'b1111;
    result  = data;
    if (load) begin
      case (size)
        MEM_B:   result = {{(XLEN-8){shifted[7]}},
                           shifted[7:0]};
        MEM_BU:  result = {{(XLEN-8){1'b0}},
                           shifted[7:0]};
        MEM_H:   result = {{(XLEN-16){shifted[15]}},
                           shifted[15:0]};
        MEM_HU:  result = {{(XLEN-16){1'b0}},
                           shifted[15:0]};
        default: result = shifted;
      endcase
    end else begin
      case (size)
        MEM_B, MEM_BU: begin
          result = {4{data[7:0]}};
          be     = 4'b0001 << off;
        end
        MEM_H, MEM_HU: begin
          result = {2{data[15:0]}};
          be     = 4'b0011 << off;
        end
        default: begin
          result = data;
          be     = 4'b1111;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access_stage.sv
// RAPID memory-access stage: dmem req/ack
// transaction, lane steering, result beat.
module mem_access_stage
  import rapid_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_valid,
  output logic            o_ready,
  input  control_s        i_control_signal,
  input  logic [XLEN-1:0] i_alu_result,
  input  logic [XLEN-1:0] i_store_data,
  input  logic [4:0]      i_rd,
  output logic            o_dmem_req,
  output logic            o_dmem_we,
  output logic [XLEN-1:0] o_dmem_addr,
  output logic [XLEN-1:0] o_dmem_wdata,
  output logic [3:0]      o_dmem_be,
  input  logic            i_dmem_ack,
  input  logic [XLEN-1:0] i_dmem_rdata,
  output logic            o_valid,
  output logic [XLEN-1:0] o_wb_data,
  output logic [4:0]      o_rd,
  output control_s        o_control_signal,
  output logic            o_misaligned
);

  mem_state_e      state;
  control_s        pend_ctrl;
  logic [XLEN-1:0] pend_addr;
  logic [4:0]      pend_rd;

  logic            is_mem;
  logic            aligned;
  logic [3:0]      st_be;
  logic [XLEN-1:0] st_wdata;
  logic [XLEN-1:0] ld_data;

  assign o_ready = (state == S_IDLE);
  assign is_mem  = i_control_signal.mem_read
                 | i_control_signal.mem_write;
  assign aligned = is_aligned(i_control_signal.mem_size,
                              i_alu_result[1:0]);

  mem_lane_align #(.XLEN(XLEN)) u_store_align (
    .size   (i_control_signal.mem_size),
    .off    (i_alu_result[1:0]),
    .load   (i_control_signal.mem_read),
    .data   (i_store_data),
    .be     (st_be),
    .result (st_wdata)
  );

  mem_lane_align #(.XLEN(XLEN)) u_load_align (
    .size   (pend_ctrl.mem_size),
    .off    (pend_addr[1:0]),
    .load   (1'b1),
    .data   (i_dmem_rdata),
    .be     (),
    .result (ld_data)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state            <= S_IDLE;
      pend_ctrl        <= '0;
      pend_addr        <= '0;
      pend_rd          <= '0;
      o_dmem_req       <= 1'b0;
      o_dmem_we        <= 1'b0;
      o_dmem_addr      <= '0;
      o_dmem_wdata     <= '0;
      o_dmem_be        <= '0;
      o_valid          <= 1'b0;
      o_wb_data        <= '0;
      o_rd             <= '0;
      o_control_signal <= '0;
      o_misaligned     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_valid && is_mem && aligned) begin
            state        <= S_WAIT;
            pend_ctrl    <= i_control_signal;
            pend_addr    <= i_alu_result;
            pend_rd      <= i_rd;
            o_dmem_req   <= 1'b1;
            o_dmem_we    <= i_control_signal.mem_write;
            o_dmem_addr  <= {i_alu_result[XLEN-1:2],
                             2'b00};
            o_dmem_wdata <= st_wdata;
            o_dmem_be    <= st_be;
          end else if (i_valid) begin
            // misaligned ops retire as a flagged
            // beat that must not write the RF
            o_valid          <= 1'b1;
            o_wb_data        <= i_alu_result;
            o_rd             <= i_rd;
            o_control_signal <= i_control_signal;
            o_misaligned     <= is_mem;
            if (is_mem) begin
              o_control_signal.reg_write <= 1'b0;
            end
          end
        end
        S_WAIT: begin
          if (i_dmem_ack) begin
            state            <= S_IDLE;
            o_dmem_req       <= 1'b0;
            o_valid          <= 1'b1;
            o_wb_data        <= pend_ctrl.mem_read
                              ? ld_data : pend_addr;
            o_rd             <= pend_rd;
            o_control_signal <= pend_ctrl;
            o_misaligned     <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage:
// directed steps plus randomized ops vs. a model.
module tb_mem_access_stage;
  import rapid_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_valid;
  logic        o_ready;
  control_s    i_control_signal;
  logic [31:0] i_alu_result;
  logic [31:0] i_store_data;
  logic [4:0]  i_rd;
  logic        o_dmem_req;
  logic        o_dmem_we;
  logic [31:0] o_dmem_addr;
  logic [31:0] o_dmem_wdata;
  logic [3:0]  o_dmem_be;
  logic        i_dmem_ack;
  logic [31:0] i_dmem_rdata;
  logic        o_valid;
  logic [31:0] o_wb_data;
  logic [4:0]  o_rd;
  control_s    o_control_signal;
  logic        o_misaligned;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 i_clk = ~i_clk;

  mem_access_stage #(.XLEN(32)) dut (
    .i_clk            (i_clk),
    .i_reset          (i_reset),
    .i_valid          (i_valid),
    .o_ready          (o_ready),
    .i_control_signal (i_control_signal),
    .i_alu_result     (i_alu_result),
    .i_store_data     (i_store_data),
    .i_rd             (i_rd),
    .o_dmem_req       (o_dmem_req),
    .o_dmem_we        (o_dmem_we),
    .o_dmem_addr      (o_dmem_addr),
    .o_dmem_wdata     (o_dmem_wdata),
    .o_dmem_be        (o_dmem_be),
    .i_dmem_ack       (i_dmem_ack),
    .i_dmem_rdata     (i_dmem_rdata),
    .o_valid          (o_valid),
    .o_wb_data        (o_wb_data),
    .o_rd             (o_rd),
    .o_control_signal (o_control_signal),
    .o_misaligned     (o_misaligned)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h",
             tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // reference model, straight from the size rules
  function automatic logic m_aligned(mem_size_e s,
                                     logic [31:0] a);
    int bytes;
    bytes = (s == MEM_W) ? 4
          : (s == MEM_H || s == MEM_HU) ? 2 : 1;
    return (a % bytes) == 0;
  endfunction

  function automatic logic [3:0] m_be(control_s c,
                                      logic [31:0] a);
    int n;
    if (c.mem_read) return 4'hf;
    n = (c.mem_size == MEM_W) ? 4
      : (c.mem_size == MEM_H ||
         c.mem_size == MEM_HU) ? 2 : 1;
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] m_wdata(mem_size_e s,
                                          logic [31:0] d);
    if (s == MEM_W) return d;
    if (s == MEM_H || s == MEM_HU)
      return (d & 32'hffff) * 32'h0001_0001;
    return (d & 32'hff) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] m_load(mem_size_e s,
                                         logic [31:0] a,
                                         logic [31:0] rd);
    logic [31:0] v;
    v = rd / (32'd1 << (8 * (a % 4)));
    case (s)
      MEM_B:   return 32'(int'($signed(v[7:0])));
      MEM_BU:  return v % 256;
      MEM_H:   return 32'(int'($signed(v[15:0])));
      MEM_HU:  return v % 65536;
      default: return v;
    endcase
  endfunction

  function automatic control_s mk(logic rw, logic mr,
                                  logic mw, mem_size_e s);
    control_s c;
    c.reg_write = rw;
    c.mem_read  = mr;
    c.mem_write = mw;
    c.mem_size  = s;
    return c;
  endfunction

  // one instruction, ending in its result-beat cycle
  task automatic op(input control_s c,
                    input logic [31:0] a,
                    input logic [31:0] sd,
                    input logic [4:0] r,
                    input int waits,
                    input logic [31:0] rdata);
    logic mem;
    logic ok;
    logic [31:0] exp_wb;
    mem = c.mem_read | c.mem_write;
    ok  = m_aligned(c.mem_size, a);
    chk("ready_pre", o_ready, 1);
    i_valid          = 1'b1;
    i_control_signal = c;
    i_alu_result     = a;
    i_store_data     = sd;
    i_rd             = r;
    tick();
    i_valid = 1'b0;
    if (!mem || !ok) begin
      chk("imm_valid", o_valid, 1);
      chk("imm_mis", o_misaligned, mem);
      chk("imm_wb", o_wb_data, a);
      chk("imm_rd", o_rd, r);
      chk("imm_rw", o_control_signal.reg_write,
          mem ? 1'b0 : c.reg_write);
      chk("imm_req", o_dmem_req, 0);
    end else begin
      for (int k = 0; k <= waits; k++) begin
        chk("req", o_dmem_req, 1);
        chk("we", o_dmem_we, c.mem_write);
        chk("addr", o_dmem_addr, a & ~32'd3);
        chk("be", o_dmem_be, m_be(c, a));
        if (c.mem_write)
          chk("wdata", o_dmem_wdata,
              m_wdata(c.mem_size, sd));
        chk("busy", o_ready, 0);
        chk("no_beat", o_valid, 0);
        if (k == waits) begin
          i_dmem_ack   = 1'b1;
          i_dmem_rdata = rdata;
        end
        tick();
      end
      i_dmem_ack   = 1'b0;
      i_dmem_rdata = $urandom;
      exp_wb = c.mem_read
             ? m_load(c.mem_size, a, rdata) : a;
      chk("m_valid", o_valid, 1);
      chk("m_wb", o_wb_data, exp_wb);
      chk("m_rd", o_rd, r);
      chk("m_rw", o_control_signal.reg_write,
          c.reg_write);
      chk("m_mis", o_misaligned, 0);
      chk("m_req", o_dmem_req, 0);
      chk("m_ready", o_ready, 1);
    end
  endtask

  initial begin
    mem_size_e sizes [5];
    control_s  c;
    int        kind;
    logic [31:0] a;
    sizes = '{MEM_B, MEM_H, MEM_W, MEM_BU, MEM_HU};

    i_reset          = 1'b1;
    i_valid          = 1'b0;
    i_control_signal = '0;
    i_alu_result     = '0;
    i_store_data     = '0;
    i_rd             = '0;
    i_dmem_ack       = 1'b0;
    i_dmem_rdata     = '0;
    repeat (3) tick();
    i_reset = 1'b0;

    chk("rst_ready", o_ready, 1);
    chk("rst_valid", o_valid, 0);
    chk("rst_req", o_dmem_req, 0);
    chk("rst_we", o_dmem_we, 0);
    chk("rst_be", o_dmem_be, 0);
    chk("rst_wb", o_wb_data, 0);
    chk("rst_ctrl", o_control_signal, 0);

    // ack while idle is ignored
    i_dmem_ack = 1'b1;
    tick();
    i_dmem_ack = 1'b0;
    chk("idle_ack", o_valid, 0);

    // ADD passthrough
    op(mk(1, 0, 0, MEM_B), 32'h1234, 0, 5, 0, 0);
    tick();
    chk("pulse", o_valid, 0);
    chk("hold_wb", o_wb_data, 32'h1234);

    // LB / LBU at 0x103, zero-wait
    op(mk(1, 1, 0, MEM_B), 32'h103, 0, 6, 0,
       32'h80FF_0011);
    chk("lb", o_wb_data, 32'hFFFF_FF80);
    op(mk(1, 1, 0, MEM_BU), 32'h103, 0, 6, 0,
       32'h80FF_0011);
    chk("lbu", o_wb_data, 32'h0000_0080);

    // SH at 0x202, three wait cycles
    op(mk(0, 0, 1, MEM_H), 32'h202, 32'hABCD, 0, 3, 0);
    chk("sh_be", o_dmem_be, 4'b1100);
    chk("sh_wd", o_dmem_wdata, 32'hABCD_ABCD);

    // LW misaligned
    op(mk(1, 1, 0, MEM_W), 32'h301, 0, 7, 0, 0);

    // reset during a pending LW, late ack
    tick();
    i_valid          = 1'b1;
    i_control_signal = mk(1, 1, 0, MEM_W);
    i_alu_result     = 32'h400;
    tick();
    i_valid = 1'b0;
    chk("rw_req", o_dmem_req, 1);
    i_reset = 1'b1;
    tick();
    i_reset = 1'b0;
    chk("rw_req0", o_dmem_req, 0);
    chk("rw_ready", o_ready, 1);
    tick();
    i_dmem_ack = 1'b1;
    tick();
    i_dmem_ack = 1'b0;
    chk("rw_noval", o_valid, 0);
    chk("rw_req1", o_dmem_req, 0);
    tick();
    chk("rw_noval2", o_valid, 0);

    // ADD, ADD, LW, then an ADD held off
    op(mk(1, 0, 0, MEM_B), 32'h11, 0, 1, 0, 0);
    op(mk(1, 0, 0, MEM_B), 32'h22, 0, 2, 0, 0);
    chk("ready_lw", o_ready, 1);
    i_valid          = 1'b1;
    i_control_signal = mk(1, 1, 0, MEM_W);
    i_alu_result     = 32'h500;
    i_rd             = 3;
    tick();
    i_control_signal = mk(1, 0, 0, MEM_B);
    i_alu_result     = 32'h55;
    i_rd             = 9;
    chk("held_rdy", o_ready, 0);
    tick();
    chk("held_rdy2", o_ready, 0);
    chk("held_val", o_valid, 0);
    i_dmem_ack   = 1'b1;
    i_dmem_rdata = 32'hCAFE_F00D;
    tick();
    i_dmem_ack = 1'b0;
    chk("lw_val", o_valid, 1);
    chk("lw_wb", o_wb_data, 32'hCAFE_F00D);
    chk("lw_rd", o_rd, 3);
    tick();
    i_valid = 1'b0;
    chk("add_val", o_valid, 1);
    chk("add_wb", o_wb_data, 32'h55);
    chk("add_rd", o_rd, 9);
    tick();

    // randomized ops against the model
    for (int n = 0; n < 60; n++) begin
      kind = $urandom_range(0, 2);
      c = mk(1'($urandom), kind == 1, kind == 2,
             sizes[$urandom_range(0, 4)]);
      a = $urandom;
      if ($urandom_range(0, 1) == 1)
        a = a & ~32'd3;
      op(c, a, $urandom, 5'($urandom),
         $urandom_range(0, 3), $urandom);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
